// File: rtl/pc_fetch_ctrl_pkg.sv
// ============================================================================
// Module : pc_fetch_ctrl_pkg
// Brief  : Shared state encoding and default reset vector for the PC/fetch block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_ctrl_pkg;

  localparam logic [15:0] c_RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : pc_fetch_ctrl_pkg

`default_nettype wire

// File: rtl/pc_fetch_ctrl_gmux16.sv
// ============================================================================
// Module : gmux16
// Brief  : Two-way word multiplexer; y = sel ? b : a.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gmux16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule : gmux16

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module : pc_fetch_ctrl
// Brief  : Program counter plus single-outstanding instruction fetch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(c_RESET_VEC),
  parameter int unsigned       STEP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_sel;
  logic             w_retire;
  logic             w_capture;

  // Increment truncates to WIDTH, so the top address wraps to zero.
  assign w_pc_inc = r_pc + WIDTH'(STEP);

  gmux16 #(
    .WIDTH (WIDTH)
  ) u_next_pc_mux (
    .a   (w_pc_inc),
    .b   (jump_addr),
    .sel (jump),
    .y   (w_pc_sel)
  );

  assign w_retire  = (r_state == HOLD) && instr_ready;
  assign w_capture = (r_state == REQ)  && mem_ack;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en && !jump) w_state_nxt = REQ;
      REQ:     if (mem_ack)     w_state_nxt = HOLD;
      HOLD:    if (instr_ready) w_state_nxt = en ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_VEC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A jump while idle only redirects the PC; no fetch is started.
      if ((r_state == IDLE) && jump) begin
        r_pc <= jump_addr;
      end else if (w_retire) begin
        r_pc <= w_pc_sel;
      end
      if (w_capture) begin
        r_instr <= mem_rdata;
      end
    end
  end

  assign mem_req     = (r_state == REQ);
  assign instr_valid = (r_state == HOLD);
  assign mem_addr    = r_pc;
  assign instr       = r_instr;
  assign pc          = r_pc;

endmodule : pc_fetch_ctrl

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// Module : tb_pc_fetch_ctrl
// Brief  : Directed and randomized checks of two fetch controllers (reset vectors 0000 / FFFF).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        jump;
  logic [15:0] jump_addr;
  logic        mem_ack;
  logic [15:0] rdata_drv;
  logic        rdata_auto;
  logic [15:0] mem_rdata;
  logic        instr_ready;

  logic        req0, req1, val0, val1;
  logic [15:0] addr0, addr1, ins0, ins1, pc0, pc1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one entry per instance
  int unsigned m_pc    [2];
  int unsigned m_instr [2];
  bit          m_wait  [2];   // read issued, data not yet returned
  bit          m_have  [2];   // word presented downstream, not yet taken
  int unsigned rvec    [2];

  assign mem_rdata = rdata_auto ? (addr0 ^ 16'hA5A5) : rdata_drv;

  pc_fetch_ctrl #(.WIDTH(16), .RESET_VEC(16'h0000), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .jump_addr(jump_addr),
    .mem_req(req0), .mem_addr(addr0), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(val0), .instr(ins0), .instr_ready(instr_ready), .pc(pc0)
  );

  pc_fetch_ctrl #(.WIDTH(16), .RESET_VEC(16'hFFFF), .STEP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .jump_addr(jump_addr),
    .mem_req(req1), .mem_addr(addr1), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(val1), .instr(ins1), .instr_ready(instr_ready), .pc(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = rvec[i]; m_instr[i] = 0; m_wait[i] = 0; m_have[i] = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pc[i] = rvec[i]; m_instr[i] = 0; m_wait[i] = 0; m_have[i] = 0;
      end else if (m_have[i]) begin
        if (instr_ready) begin
          m_pc[i]   = jump ? jump_addr : (m_pc[i] + 1) % 65536;
          m_have[i] = 0;
          m_wait[i] = en;
        end
      end else if (m_wait[i]) begin
        if (mem_ack) begin
          m_instr[i] = mem_rdata;
          m_wait[i]  = 0;
          m_have[i]  = 1;
        end
      end else if (jump) begin
        m_pc[i] = jump_addr;
      end else if (en) begin
        m_wait[i] = 1;
      end
    end
  endtask

  task automatic compare_inst(input int i, input logic req, input logic [15:0] addr,
                              input logic val, input logic [15:0] ins, input logic [15:0] pcv);
    string p;
    p = (i == 0) ? "u0" : "u1";
    check({p, ".mem_req"},     {31'd0, req}, {31'd0, m_wait[i]});
    check({p, ".instr_valid"}, {31'd0, val}, {31'd0, m_have[i]});
    check({p, ".pc"},          {16'd0, pcv}, m_pc[i]);
    check({p, ".instr"},       {16'd0, ins}, m_instr[i]);
    if (req) check({p, ".mem_addr"}, {16'd0, addr}, m_pc[i]);
  endtask

  task automatic compare_all();
    compare_inst(0, req0, addr0, val0, ins0, pc0);
    compare_inst(1, req1, addr1, val1, ins1, pc1);
  endtask

  // Inputs are changed only at the falling edge; outputs checked there too.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic e, input logic j, input logic [15:0] ja,
                       input logic a, input logic r);
    en = e; jump = j; jump_addr = ja; mem_ack = a; instr_ready = r;
  endtask

  logic [15:0] hold_instr, hold_pc;

  initial begin
    rvec[0] = 32'h0000; rvec[1] = 32'hFFFF;
    rst_n = 1'b0; rdata_auto = 1'b0; rdata_drv = 16'h0;
    drive(0, 0, 16'h0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.pc0", {16'd0, pc0}, 32'h0000);
    check("rst.pc1", {16'd0, pc1}, 32'hFFFF);
    check("rst.addr0", {16'd0, addr0}, 32'h0000);
    compare_all();
    rst_n = 1'b1;

    // Sequential fetch with rdata = addr ^ A5A5
    rdata_auto = 1'b1;
    drive(1, 0, 16'h0, 1, 1);
    step(); check("seq.addr0", {16'd0, addr0}, 32'h0000); check("seq.req0", {31'd0, req0}, 1);
    step(); check("seq.instr0", {16'd0, ins0}, 32'hA5A5);
    step(); check("seq.addr1", {16'd0, addr0}, 32'h0001);
    check("wrap.pc", {16'd0, pc1}, 32'h0000);
    step(); check("seq.instr1", {16'd0, ins0}, 32'hA5A4);
    step(); check("seq.addr2", {16'd0, addr0}, 32'h0002);
    step(); check("seq.instr2", {16'd0, ins0}, 32'hA5A7);
    step(); step();
    check("jmp.pc_before", {16'd0, pc0}, 32'h0003);
    check("jmp.in_hold", {31'd0, val0}, 1);

    // Jump at retire, then jump during REQ ignored
    drive(1, 1, 16'h1234, 0, 1);
    step(); check("jmp.addr", {16'd0, addr0}, 32'h1234);
    drive(1, 1, 16'h5555, 0, 1);
    step(); step();
    check("jmp.req_ignored", {16'd0, addr0}, 32'h1234);
    check("stall.req", {31'd0, req0}, 1);
    drive(1, 0, 16'h0, 1, 0);
    step();
    hold_instr = ins0; hold_pc = pc0;
    check("stall.instr_val", {16'd0, hold_instr}, 32'h1234 ^ 32'hA5A5);
    repeat (4) begin
      step();
      check("stall.valid", {31'd0, val0}, 1);
      check("stall.instr", {16'd0, ins0}, {16'd0, hold_instr});
      check("stall.pc", {16'd0, pc0}, {16'd0, hold_pc});
    end
    drive(1, 0, 16'h0, 0, 1);
    step(); check("seq.after_jump", {16'd0, addr0}, 32'h1235);

    // en drop in REQ: completes, retires, then idle
    drive(0, 0, 16'h0, 1, 0);
    step(); check("endrop.valid", {31'd0, val0}, 1);
    drive(0, 0, 16'h0, 0, 1);
    step(); check("endrop.idle_req", {31'd0, req0}, 0);
    step(); check("endrop.stay", {31'd0, req0}, 0);
    check("endrop.pc", {16'd0, pc0}, 32'h1236);

    // Reset mid-REQ, stale ack afterwards must be ignored
    drive(1, 0, 16'h0, 0, 0);
    step(); check("rst2.in_req", {31'd0, req0}, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst2.pc", {16'd0, pc0}, 32'h0000);
    check("rst2.req", {31'd0, req0}, 0);
    check("rst2.valid", {31'd0, val0}, 0);
    @(negedge clk);
    drive(0, 0, 16'h0, 1, 1);
    rst_n = 1'b1;
    repeat (3) step();
    check("rst2.idle", {31'd0, req0}, 0);

    // Randomized traffic
    rdata_auto = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1));
      rdata_drv = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_fetch_ctrl

`default_nettype wire
